// File: rtl/sdram_bfm_if.sv
// -----------------------------------------------------------------------------
// sdram_bfm_if
//   SDR SDRAM pin bundle between a controller and the sdram_bfm device model.
//
//   Signals
//     cke                   clock enable (controller -> device)
//     cs_n/ras_n/cas_n/we_n command pins
//     ba [BA_W]             bank address
//     a  [ROW_W]            row / column / mode address
//     dq_in [DATA_W]        write data
//     dm [DATA_W/8]         write byte mask, 1 masks the byte
//     dq_out [DATA_W]       read data (device -> controller)
//     dq_oe                 dq_out carries a read beat
//     bank_open [2^BA_W]    per-bank row-open status
//     err_flag              one-cycle protocol-violation pulse
//     err_count [8]         saturating violation count
//
//   Modports: master = controller side, slave = device side.
// -----------------------------------------------------------------------------
interface sdram_bfm_if #(
  parameter int DATA_W = 16,
  parameter int ROW_W  = 13,
  parameter int BA_W   = 2
);
  logic                   cke;
  logic                   cs_n;
  logic                   ras_n;
  logic                   cas_n;
  logic                   we_n;
  logic [BA_W-1:0]        ba;
  logic [ROW_W-1:0]       a;
  logic [DATA_W-1:0]      dq_in;
  logic [DATA_W/8-1:0]    dm;
  logic [DATA_W-1:0]      dq_out;
  logic                   dq_oe;
  logic [(2**BA_W)-1:0]   bank_open;
  logic                   err_flag;
  logic [7:0]             err_count;

  modport master (
    output cke, cs_n, ras_n, cas_n, we_n, ba, a, dq_in, dm,
    input  dq_out, dq_oe, bank_open, err_flag, err_count
  );

  modport slave (
    input  cke, cs_n, ras_n, cas_n, we_n, ba, a, dq_in, dm,
    output dq_out, dq_oe, bank_open, err_flag, err_count
  );
endinterface

// File: rtl/sdram_bfm.sv
// -----------------------------------------------------------------------------
// sdram_bfm
//   Synthesisable SDR SDRAM device model. Decodes the SDR command set, tracks
//   the open row per bank, honours the mode-register CAS latency (2/3) and
//   sequential burst length (1/2/4/8), applies byte masks on writes and flags
//   protocol violations for controller benches.
//
//   Ports
//     clk_sys   clock, all state updates on the rising edge
//     rst_n     asynchronous active-low reset
//     bus       sdram_bfm_if.slave pin bundle
//
//   Optional feature
//     SDRAM_BFM_TIMING_CHECK_EN  when defined, builds tRCD / tRP / tRFC
//     spacing counters; violations are flagged but the command still executes.
//
//   Backing store: 2^MEM_AW words indexed by the low MEM_AW bits of
//   {ba,row,col}. Contents are never cleared by reset.
// -----------------------------------------------------------------------------
module sdram_bfm #(
  parameter int DATA_W = 16,
  parameter int ROW_W  = 13,
  parameter int COL_W  = 9,
  parameter int BA_W   = 2,
  parameter int MEM_AW = 16,
  parameter int T_RCD  = 2,
  parameter int T_RP   = 2,
  parameter int T_RFC  = 7
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  sdram_bfm_if.slave  bus
);

  localparam int BANKS = 2**BA_W;
  localparam int NBYTE = DATA_W/8;

  typedef enum logic [2:0] {
    CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF, CMD_LMR, CMD_BST
  } cmd_e;

  typedef enum logic [1:0] {BST_IDLE, BST_READ, BST_WRITE} bst_state_e;

  typedef struct packed {
    logic              valid;
    logic [MEM_AW-1:0] idx;
  } rd_ent_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] r_mem [2**MEM_AW];
  logic [ROW_W-1:0]  r_row [BANKS];
  logic [BANKS-1:0]  r_bank_open;
  logic              r_cl3;        // 1: CL=3, 0: CL=2
  logic [2:0]        r_bl_mask;    // BL-1
  bst_state_e        r_bst_state;
  logic [BA_W-1:0]   r_bst_bank;
  logic [COL_W-1:0]  r_bst_col;    // starting column of the burst
  logic [2:0]        r_bst_beat;   // index of the next beat to emit
  logic [2:0]        r_bst_last;   // BL-1 latched at burst start
  logic              r_bst_ap;
  rd_ent_t           r_pipe [2];
  logic [DATA_W-1:0] r_dq_out;
  logic              r_dq_oe;
  logic              r_err_flag;
  logic [7:0]        r_err_count;

  cmd_e              w_cmd;
  logic              w_any_open;
  logic              w_bank_is_open;
  logic              w_rw_ok;
  logic              w_act_ok;
  logic              w_lmr_ok;
  logic              w_bl_bad;
  logic              w_cl_bad;
  logic              w_proto_err;
  logic              w_tim_err;
  logic              w_err;
  logic              w_stop;
  bst_state_e        w_bst_nxt;
  logic              w_gen_rd;
  logic              w_gen_wr;
  logic              w_gen_last;
  logic              w_gen_ap;
  logic [BA_W-1:0]   w_gen_bank;
  logic [COL_W-1:0]  w_gen_col;
  logic [COL_W-1:0]  w_bst_mask;
  logic [MEM_AW-1:0] w_gen_idx;
  logic              w_ap_fire;
  rd_ent_t           w_out_ent;

  function automatic logic [MEM_AW-1:0] f_idx(input logic [BA_W-1:0]  b,
                                               input logic [ROW_W-1:0] r,
                                               input logic [COL_W-1:0] c);
    return MEM_AW'({b, r, c});
  endfunction

  // ---------------------------------------------------------------------------
  // Command decode and legality
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_cmd = CMD_NOP;
    if (!bus.cs_n) begin
      case ({bus.ras_n, bus.cas_n, bus.we_n})
        3'b011:  w_cmd = CMD_ACT;
        3'b101:  w_cmd = CMD_RD;
        3'b100:  w_cmd = CMD_WR;
        3'b010:  w_cmd = CMD_PRE;
        3'b001:  w_cmd = CMD_REF;
        3'b000:  w_cmd = CMD_LMR;
        3'b110:  w_cmd = CMD_BST;
        default: w_cmd = CMD_NOP;
      endcase
    end
  end

  assign w_any_open     = |r_bank_open;
  assign w_bank_is_open = r_bank_open[bus.ba];
  assign w_rw_ok        = (w_cmd == CMD_RD || w_cmd == CMD_WR) && w_bank_is_open;
  assign w_act_ok       = (w_cmd == CMD_ACT) && !w_bank_is_open;
  assign w_lmr_ok       = (w_cmd == CMD_LMR) && !w_any_open;
  assign w_bl_bad       = bus.a[2:0] > 3'd3;
  assign w_cl_bad       = (bus.a[6:4] != 3'd2) && (bus.a[6:4] != 3'd3);

  assign w_proto_err = ((w_cmd == CMD_RD || w_cmd == CMD_WR) && !w_bank_is_open)
                     || ((w_cmd == CMD_ACT) && w_bank_is_open)
                     || ((w_cmd == CMD_LMR || w_cmd == CMD_REF) && w_any_open)
                     || (w_lmr_ok && (w_bl_bad || w_cl_bad));

  // Multiple simultaneous violations collapse into a single count.
  assign w_err = w_proto_err || w_tim_err;

  // Anything that ends the running burst this edge; ignored READ/WRITEs do not.
  assign w_stop = w_rw_ok || (w_cmd == CMD_BST)
               || ((w_cmd == CMD_PRE) && (bus.a[10] || bus.ba == r_bst_bank));

  // ---------------------------------------------------------------------------
  // Burst generator FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_bst_state <= BST_IDLE;
    end else if (bus.cke) begin
      r_bst_state <= w_bst_nxt;
    end
  end

  always_comb begin
    w_bst_nxt = r_bst_state;
    if (r_bst_state != BST_IDLE && (w_stop || r_bst_beat == r_bst_last))
      w_bst_nxt = BST_IDLE;
    // Beat 0 is emitted on the command edge, so only BL>1 needs the generator.
    if (w_rw_ok && r_bl_mask != 3'd0)
      w_bst_nxt = (w_cmd == CMD_RD) ? BST_READ : BST_WRITE;
  end

  assign w_bst_mask = COL_W'(r_bst_last);

  always_comb begin
    w_gen_rd   = 1'b0;
    w_gen_wr   = 1'b0;
    w_gen_last = 1'b0;
    w_gen_ap   = 1'b0;
    w_gen_bank = r_bst_bank;
    // Sequential wrap inside the BL-aligned block.
    w_gen_col  = (r_bst_col & ~w_bst_mask)
               | ((r_bst_col + COL_W'(r_bst_beat)) & w_bst_mask);
    if (w_rw_ok) begin
      w_gen_rd   = (w_cmd == CMD_RD);
      w_gen_wr   = (w_cmd == CMD_WR);
      w_gen_last = (r_bl_mask == 3'd0);
      w_gen_ap   = bus.a[10];
      w_gen_bank = bus.ba;
      w_gen_col  = bus.a[COL_W-1:0];
    end else if (r_bst_state != BST_IDLE && !w_stop) begin
      w_gen_rd   = (r_bst_state == BST_READ);
      w_gen_wr   = (r_bst_state == BST_WRITE);
      w_gen_last = (r_bst_beat == r_bst_last);
      w_gen_ap   = r_bst_ap;
    end
  end

  assign w_gen_idx = f_idx(w_gen_bank, r_row[w_gen_bank], w_gen_col);
  assign w_ap_fire = (w_gen_rd || w_gen_wr) && w_gen_last && w_gen_ap;

  // ---------------------------------------------------------------------------
  // Bank, mode, burst bookkeeping and violation reporting
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_row       <= '{default: '0};
      r_bank_open <= '0;
      r_cl3       <= 1'b0;
      r_bl_mask   <= 3'd0;
      r_bst_bank  <= '0;
      r_bst_col   <= '0;
      r_bst_beat  <= 3'd0;
      r_bst_last  <= 3'd0;
      r_bst_ap    <= 1'b0;
      r_err_flag  <= 1'b0;
      r_err_count <= 8'd0;
    end else if (bus.cke) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values; later assignments in this block win.
      r_err_flag <= w_err;
      if (w_err && r_err_count != 8'hFF)
        r_err_count <= r_err_count + 8'd1;

      if (w_act_ok) begin
        r_row[bus.ba]       <= bus.a;
        r_bank_open[bus.ba] <= 1'b1;
      end
      if (w_cmd == CMD_PRE) begin
        if (bus.a[10]) r_bank_open         <= '0;
        else           r_bank_open[bus.ba] <= 1'b0;
      end
      if (w_ap_fire)
        r_bank_open[w_gen_bank] <= 1'b0;

      if (w_lmr_ok) begin
        case (bus.a[2:0])
          3'd1:    r_bl_mask <= 3'd1;
          3'd2:    r_bl_mask <= 3'd3;
          3'd3:    r_bl_mask <= 3'd7;
          default: r_bl_mask <= 3'd0;
        endcase
        r_cl3 <= (bus.a[6:4] == 3'd3);
      end

      if (w_rw_ok) begin
        r_bst_bank <= bus.ba;
        r_bst_col  <= bus.a[COL_W-1:0];
        r_bst_beat <= 3'd1;
        r_bst_last <= r_bl_mask;
        r_bst_ap   <= bus.a[10];
      end else if (w_gen_rd || w_gen_wr) begin
        r_bst_beat <= r_bst_beat + 3'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Backing store
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset branch; clearing a RAM on reset is not
  // something real storage can do, and the contents must survive rst_n.
  always_ff @(posedge clk_sys) begin
    if (bus.cke && w_gen_wr) begin
      for (int i = 0; i < NBYTE; i++) begin
        if (!bus.dm[i])
          r_mem[w_gen_idx][8*i +: 8] <= bus.dq_in[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline: entry enters r_pipe[0] on the command edge; the output
  // register fetches at stage CL-2, so data is registered at edge n+CL-1.
  // ---------------------------------------------------------------------------
  assign w_out_ent = r_cl3 ? r_pipe[1] : r_pipe[0];

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe[0] <= '0;
      r_pipe[1] <= '0;
      r_dq_oe   <= 1'b0;
      r_dq_out  <= '0;
    end else if (bus.cke) begin
      r_pipe[0] <= '{valid: w_gen_rd, idx: w_gen_idx};
      r_pipe[1] <= r_pipe[0];
      r_dq_oe   <= w_out_ent.valid;
      if (w_out_ent.valid)
        r_dq_out <= r_mem[w_out_ent.idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Optional spacing checks
  // ---------------------------------------------------------------------------
`ifdef SDRAM_BFM_TIMING_CHECK_EN
  // A counter loaded with T-1 reads zero exactly when at least T edges have
  // passed since the loading command.
  localparam logic [7:0] RCD_LD = (T_RCD > 1) ? 8'(T_RCD - 1) : 8'd0;
  localparam logic [7:0] RP_LD  = (T_RP  > 1) ? 8'(T_RP  - 1) : 8'd0;
  localparam logic [7:0] RFC_LD = (T_RFC > 1) ? 8'(T_RFC - 1) : 8'd0;

  logic [7:0] r_rcd_cnt [BANKS];
  logic [7:0] r_rp_cnt  [BANKS];
  logic [7:0] r_rfc_cnt;

  assign w_tim_err = ((w_cmd == CMD_RD || w_cmd == CMD_WR) && r_rcd_cnt[bus.ba] != 8'd0)
                  || ((w_cmd == CMD_ACT) && r_rp_cnt[bus.ba] != 8'd0)
                  || ((w_cmd != CMD_NOP) && r_rfc_cnt != 8'd0);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_rcd_cnt <= '{default: '0};
      r_rp_cnt  <= '{default: '0};
      r_rfc_cnt <= 8'd0;
    end else if (bus.cke) begin
      for (int b = 0; b < BANKS; b++) begin
        if (r_rcd_cnt[b] != 8'd0) r_rcd_cnt[b] <= r_rcd_cnt[b] - 8'd1;
        if (r_rp_cnt[b]  != 8'd0) r_rp_cnt[b]  <= r_rp_cnt[b]  - 8'd1;
      end
      if (r_rfc_cnt != 8'd0) r_rfc_cnt <= r_rfc_cnt - 8'd1;

      if (w_act_ok) r_rcd_cnt[bus.ba] <= RCD_LD;
      if (w_cmd == CMD_PRE) begin
        if (bus.a[10]) r_rp_cnt         <= '{default: RP_LD};
        else           r_rp_cnt[bus.ba] <= RP_LD;
      end
      if (w_ap_fire) r_rp_cnt[w_gen_bank] <= RP_LD;
      if (w_cmd == CMD_REF && !w_any_open) r_rfc_cnt <= RFC_LD;
    end
  end
`else
  assign w_tim_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.dq_out    = r_dq_out;
  assign bus.dq_oe     = r_dq_oe;
  assign bus.bank_open = r_bank_open;
  assign bus.err_flag  = r_err_flag;
  assign bus.err_count = r_err_count;

endmodule
